// File: rtl/uart_alu_frame.sv
// Collects an A/B/opcode frame from a UART receiver, presents the operands to an
// external ALU and streams the result back MSB byte first. Define UART_ALU_CHECKSUM_EN for the XOR check byte.
module uart_alu_frame #(
  parameter int N                 = 8,
  parameter int BYTES_PER_OPERAND = 2,
  parameter int TIMEOUT_CYCLES    = 100000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N-1:0]                   i_data_rx,
  input  logic                           i_rx_valid,
  input  logic                           i_tx_done,
  input  logic [N*BYTES_PER_OPERAND-1:0] i_alu_result,
  output logic [N*BYTES_PER_OPERAND-1:0] o_A,
  output logic [N*BYTES_PER_OPERAND-1:0] o_B,
  output logic [N-1:0]                   o_op,
  output logic [N-1:0]                   o_tx,
  output logic                           o_tx_start,
  output logic                           o_busy,
  output logic                           o_error
);
  localparam int W  = N * BYTES_PER_OPERAND;
  localparam int CW = $clog2(BYTES_PER_OPERAND + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(BYTES_PER_OPERAND);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef UART_ALU_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, RX_A, RX_B, RX_OP, RX_CHK, EXEC, TX_SEND, TX_WAIT} state_t;
`else
  typedef enum logic [2:0] {IDLE, RX_A, RX_B, RX_OP, EXEC, TX_SEND, TX_WAIT} state_t;
`endif

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, sh_q, sh_d;
  logic [N-1:0]  op_q, op_d, tx_q, tx_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          rx_state, tmo_fire;
  logic [W-1:0]  rx_ext;

  assign rx_ext  = W'(i_data_rx);
  assign cnt_inc = cnt_q + CW'(1);

`ifdef UART_ALU_CHECKSUM_EN
  logic [N-1:0] chk_q, chk_d;

  // Running XOR of every A, B and opcode byte; the first byte of a frame restarts it.
  always_comb begin
    chk_d = chk_q;
    if (i_rx_valid) begin
      if (state_q == IDLE)
        chk_d = i_data_rx;
      else if (state_q == RX_A || state_q == RX_B || state_q == RX_OP)
        chk_d = chk_q ^ i_data_rx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) chk_q <= '0;
    else       chk_q <= chk_d;
  end
`endif

  always_comb begin
    rx_state = (state_q == RX_A) || (state_q == RX_B) || (state_q == RX_OP);
`ifdef UART_ALU_CHECKSUM_EN
    if (state_q == RX_CHK) rx_state = 1'b1;
`endif
  end

  // A byte arriving in the expiry cycle wins because the fire condition requires !i_rx_valid.
  assign tmo_fire = rx_state && !i_rx_valid && (tmo_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    tmo_d   = '0;
    if (rx_state && !i_rx_valid)
      tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + TW'(1);

    case (state_q)
      IDLE: if (i_rx_valid) begin
        a_d = (a_q << N) | rx_ext;
        if (CNT_FULL == CW'(1)) begin
          state_d = RX_B;
          cnt_d   = '0;
        end else begin
          state_d = RX_A;
          cnt_d   = CW'(1);
        end
      end
      RX_A: if (i_rx_valid) begin
        a_d   = (a_q << N) | rx_ext;
        cnt_d = cnt_inc;
        if (cnt_inc == CNT_FULL) begin
          state_d = RX_B;
          cnt_d   = '0;
        end
      end
      RX_B: if (i_rx_valid) begin
        b_d   = (b_q << N) | rx_ext;
        cnt_d = cnt_inc;
        if (cnt_inc == CNT_FULL) begin
          state_d = RX_OP;
          cnt_d   = '0;
        end
      end
      RX_OP: if (i_rx_valid) begin
        op_d = i_data_rx;
`ifdef UART_ALU_CHECKSUM_EN
        state_d = RX_CHK;
`else
        state_d = EXEC;
`endif
      end
`ifdef UART_ALU_CHECKSUM_EN
      RX_CHK: if (i_rx_valid) begin
        if (i_data_rx == chk_q) begin
          state_d = EXEC;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      EXEC: begin
        sh_d    = i_alu_result;
        cnt_d   = CNT_FULL;
        state_d = TX_SEND;
      end
      TX_SEND: begin
        tx_d    = sh_q[W-1 -: N];
        state_d = TX_WAIT;
      end
      TX_WAIT: if (i_tx_done) begin
        sh_d    = sh_q << N;
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? IDLE : TX_SEND;
      end
      default: state_d = IDLE;
    endcase

    if (tmo_fire) begin
      err_d   = 1'b1;
      state_d = IDLE;
      cnt_d   = '0;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      sh_q    <= '0;
      tx_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // o_tx shows the new byte during TX_SEND itself and is held in tx_q afterwards.
  assign o_tx       = (state_q == TX_SEND) ? sh_q[W-1 -: N] : tx_q;
  assign o_tx_start = (state_q == TX_SEND);
  assign o_busy     = (state_q != IDLE);
  assign o_error    = err_q;
  assign o_A        = a_q;
  assign o_B        = b_q;
  assign o_op       = op_q;

endmodule

// File: tb/tb_uart_alu_frame.sv
// Randomized self-checking bench for uart_alu_frame (N=8, 2 bytes/operand, timeout 64).
// Exercises the checksum scenarios when UART_ALU_CHECKSUM_EN is defined.
module tb_uart_alu_frame;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  i_data_rx;
  logic        i_rx_valid;
  logic        i_tx_done;
  logic [15:0] alu_result;
  logic [15:0] o_A, o_B;
  logic [7:0]  o_op, o_tx;
  logic        o_tx_start, o_busy, o_error;

  int vectors = 0;
  int miscompares = 0;
  int n_starts = 0;
  int n_err = 0;
  bit tx_noise = 1'b0;
  logic [7:0] txq[$];

  uart_alu_frame #(.N(8), .BYTES_PER_OPERAND(2), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .i_data_rx(i_data_rx), .i_rx_valid(i_rx_valid),
    .i_tx_done(i_tx_done), .i_alu_result(alu_result), .o_A(o_A), .o_B(o_B),
    .o_op(o_op), .o_tx(o_tx), .o_tx_start(o_tx_start), .o_busy(o_busy), .o_error(o_error)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op);
    case (op)
      8'h20:   return a + b;
      8'h21:   return a - b;
      8'h22:   return a ^ b;
      default: return a & b;
    endcase
  endfunction

  assign alu_result = alu_f(o_A, o_B, o_op);

  always @(negedge clk) begin
    if (o_tx_start === 1'b1) n_starts++;
    if (o_error === 1'b1) n_err++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_data_rx  = b;
    i_rx_valid = 1'b1;
    i_tx_done  = tx_noise ? 1'($urandom_range(0, 1)) : 1'b0;
    idle(1);
    i_rx_valid = 1'b0;
    i_tx_done  = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op, input int maxgap);
    logic [7:0] bytes[$];
    bytes.push_back(a[15:8]);
    bytes.push_back(a[7:0]);
    bytes.push_back(b[15:8]);
    bytes.push_back(b[7:0]);
    bytes.push_back(op);
`ifdef UART_ALU_CHECKSUM_EN
    bytes.push_back(a[15:8] ^ a[7:0] ^ b[15:8] ^ b[7:0] ^ op);
`endif
    foreach (bytes[i]) begin
      if (i != 0 && maxgap > 0) idle($urandom_range(0, maxgap));
      send_byte(bytes[i]);
    end
  endtask

  // Acts as the transmitter: records each started byte and answers with a tx_done later.
  task automatic collect_tx(input bit pending, input int max_wait);
    int budget;
    bit pend;
    budget = 400;
    pend = pending;
    txq.delete();
    while (o_busy && budget > 0) begin
      if (pend || o_tx_start) begin
        if (o_tx_start) txq.push_back(o_tx);
        pend = 1'b0;
        idle($urandom_range(1, max_wait));
        i_tx_done = 1'b1;
        idle(1);
        i_tx_done = 1'b0;
      end else begin
        idle(1);
      end
      budget--;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    vectors++; if (o_A !== 16'h0) begin miscompares++; $display("FAIL reset_A: got %h want 0000", o_A); end
    vectors++; if (o_B !== 16'h0) begin miscompares++; $display("FAIL reset_B: got %h want 0000", o_B); end
    vectors++; if (o_op !== 8'h0) begin miscompares++; $display("FAIL reset_op: got %h want 00", o_op); end
    vectors++; if (o_tx !== 8'h0) begin miscompares++; $display("FAIL reset_tx: got %h want 00", o_tx); end
    vectors++; if ({o_tx_start, o_busy, o_error} !== 3'b000)
      begin miscompares++; $display("FAIL reset_ctrl: got start/busy/err %b want 000", {o_tx_start, o_busy, o_error}); end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_basic();
    send_frame(16'h1234, 16'h0001, 8'h20, 0);
    vectors++; if (o_A !== 16'h1234) begin miscompares++; $display("FAIL basic_A: got %h want 1234", o_A); end
    vectors++; if (o_B !== 16'h0001) begin miscompares++; $display("FAIL basic_B: got %h want 0001", o_B); end
    vectors++; if (o_op !== 8'h20) begin miscompares++; $display("FAIL basic_op: got %h want 20", o_op); end
    vectors++; if (o_tx_start !== 1'b0) begin miscompares++; $display("FAIL basic_start_k1: got %b want 0", o_tx_start); end
    idle(1);
    vectors++; if (o_tx_start !== 1'b1) begin miscompares++; $display("FAIL basic_start_k2: got %b want 1", o_tx_start); end
    vectors++; if (o_tx !== 8'h12) begin miscompares++; $display("FAIL basic_tx0: got %h want 12", o_tx); end
    idle(1);
    vectors++; if (o_tx_start !== 1'b0) begin miscompares++; $display("FAIL basic_start_wait: got %b want 0", o_tx_start); end
    idle(3);
    vectors++; if (o_tx !== 8'h12) begin miscompares++; $display("FAIL basic_tx_hold: got %h want 12", o_tx); end
    i_tx_done = 1'b1;
    idle(1);
    i_tx_done = 1'b0;
    vectors++; if (o_tx_start !== 1'b1) begin miscompares++; $display("FAIL basic_start2: got %b want 1", o_tx_start); end
    vectors++; if (o_tx !== 8'h35) begin miscompares++; $display("FAIL basic_tx1: got %h want 35", o_tx); end
    idle(1);
    i_tx_done = 1'b1;
    idle(1);
    i_tx_done = 1'b0;
    vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL basic_idle: got busy %b want 0", o_busy); end
    vectors++; if (o_A !== 16'h1234 || o_op !== 8'h20)
      begin miscompares++; $display("FAIL basic_retain: got A=%h op=%h want A=1234 op=20", o_A, o_op); end
  endtask

  task automatic test_timeout();
    int s0, e0;
    logic [15:0] a, b, exp;
    s0 = n_starts;
    e0 = n_err;
    send_byte(8'h12);
    send_byte(8'h34);
    idle(63);
    vectors++; if (o_busy !== 1'b1 || n_err != e0)
      begin miscompares++; $display("FAIL tmo_early: got busy=%b errs=%0d want busy=1 errs=%0d", o_busy, n_err - e0, 0); end
    idle(1);
    vectors++; if (o_error !== 1'b1 || o_busy !== 1'b0)
      begin miscompares++; $display("FAIL tmo_fire: got err=%b busy=%b want err=1 busy=0", o_error, o_busy); end
    idle(2);
    vectors++; if (n_err - e0 != 1) begin miscompares++; $display("FAIL tmo_pulses: got %0d want 1", n_err - e0); end
    vectors++; if (n_starts != s0) begin miscompares++; $display("FAIL tmo_nostart: got %0d starts want 0", n_starts - s0); end
    vectors++; if (o_A !== 16'h1234) begin miscompares++; $display("FAIL tmo_retainA: got %h want 1234", o_A); end

    // A byte landing in the expiry cycle is accepted and no error is raised.
    e0 = n_err;
    send_byte(8'h56);
    idle(63);
    send_byte(8'h78);
    vectors++; if (o_A !== 16'h5678 || o_error !== 1'b0)
      begin miscompares++; $display("FAIL tmo_race: got A=%h err=%b want A=5678 err=0", o_A, o_error); end
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h21);
`ifdef UART_ALU_CHECKSUM_EN
    send_byte(8'h56 ^ 8'h78 ^ 8'h03 ^ 8'h21);
`endif
    collect_tx(1'b0, 2);
    vectors++; if (txq.size() != 2 || n_err != e0)
      begin miscompares++; $display("FAIL tmo_race_tx: got %0d bytes %0d errs want 2 bytes 0 errs", txq.size(), n_err - e0); end
    else begin
      vectors++; if ({txq[0], txq[1]} !== 16'h5675)
        begin miscompares++; $display("FAIL tmo_race_res: got %h%h want 5675", txq[0], txq[1]); end
    end

    a = 16'($urandom);
    b = 16'($urandom);
    exp = alu_f(a, b, 8'h20);
    send_frame(a, b, 8'h20, 3);
    collect_tx(1'b0, 3);
    vectors++; if (txq.size() != 2 || o_busy !== 1'b0)
      begin miscompares++; $display("FAIL tmo_after_tx: got %0d bytes busy=%b want 2 bytes busy=0", txq.size(), o_busy); end
    else begin
      vectors++; if ({txq[0], txq[1]} !== exp)
        begin miscompares++; $display("FAIL tmo_after_res: got %h%h want %h", txq[0], txq[1], exp); end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, exp;
    logic [7:0] op;
    for (int f = 0; f < 10; f++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      op = 8'h20 + 8'($urandom_range(0, 3));
      exp = alu_f(a, b, op);
      tx_noise = 1'b1;
      send_frame(a, b, op, (f < 3) ? 0 : 8);
      tx_noise = 1'b0;
      vectors++; if (o_A !== a || o_B !== b || o_op !== op)
        begin miscompares++; $display("FAIL rand_regs f%0d: got %h/%h/%h want %h/%h/%h", f, o_A, o_B, o_op, a, b, op); end
      collect_tx(1'b0, (f < 3) ? 1 : 4);
      vectors++; if (txq.size() != 2 || o_busy !== 1'b0)
        begin miscompares++; $display("FAIL rand_count f%0d: got %0d bytes busy=%b want 2 busy=0", f, txq.size(), o_busy); end
      else begin
        vectors++; if ({txq[0], txq[1]} !== exp)
          begin miscompares++; $display("FAIL rand_res f%0d: got %h%h want %h", f, txq[0], txq[1], exp); end
      end
    end
  endtask

  task automatic test_rx_during_tx();
    logic [15:0] a, b, exp, na;
    logic [7:0] first;
    a = 16'($urandom);
    b = 16'($urandom);
    exp = alu_f(a, b, 8'h22);
    send_frame(a, b, 8'h22, 0);
    idle(1);
    first = o_tx;
    idle(1);
    send_byte(8'hAA);
    vectors++; if (o_busy !== 1'b1 || o_A !== a || o_error !== 1'b0)
      begin miscompares++; $display("FAIL rxtx_drop: got busy=%b A=%h err=%b want 1 %h 0", o_busy, o_A, o_error, a); end
    collect_tx(1'b1, 3);
    vectors++; if (first !== exp[15:8]) begin miscompares++; $display("FAIL rxtx_b0: got %h want %h", first, exp[15:8]); end
    vectors++; if (txq.size() != 1) begin miscompares++; $display("FAIL rxtx_count: got %0d want 1", txq.size()); end
    else begin
      vectors++; if (txq[0] !== exp[7:0]) begin miscompares++; $display("FAIL rxtx_b1: got %h want %h", txq[0], exp[7:0]); end
    end
    send_byte(8'h5A);
    vectors++; if (o_A !== {a[7:0], 8'h5A} || o_busy !== 1'b1)
      begin miscompares++; $display("FAIL rxtx_next_A: got %h want %h", o_A, {a[7:0], 8'h5A}); end
    na = 16'h5A3C;
    send_byte(8'h3C);
    send_byte(b[15:8]);
    send_byte(b[7:0]);
    send_byte(8'h20);
`ifdef UART_ALU_CHECKSUM_EN
    send_byte(8'h5A ^ 8'h3C ^ b[15:8] ^ b[7:0] ^ 8'h20);
`endif
    exp = alu_f(na, b, 8'h20);
    collect_tx(1'b0, 2);
    vectors++; if (txq.size() != 2) begin miscompares++; $display("FAIL rxtx_next_count: got %0d want 2", txq.size()); end
    else begin
      vectors++; if ({txq[0], txq[1]} !== exp)
        begin miscompares++; $display("FAIL rxtx_next_res: got %h%h want %h", txq[0], txq[1], exp); end
    end
  endtask

  task automatic test_reset_mid_tx();
    int s0, e0;
    send_frame(16'hBEEF, 16'h0101, 8'h20, 0);
    idle(1);
    vectors++; if (o_tx_start !== 1'b1 || o_tx !== 8'hBF)
      begin miscompares++; $display("FAIL rst_tx_first: got start=%b tx=%h want 1 BF", o_tx_start, o_tx); end
    idle(3);
    reset = 1'b1;
    idle(1);
    vectors++; if ({o_A, o_B, o_op, o_tx} !== 48'h0)
      begin miscompares++; $display("FAIL rst_tx_data: got %h want 0", {o_A, o_B, o_op, o_tx}); end
    vectors++; if ({o_tx_start, o_busy, o_error} !== 3'b000)
      begin miscompares++; $display("FAIL rst_tx_ctrl: got %b want 000", {o_tx_start, o_busy, o_error}); end
    reset = 1'b0;
    s0 = n_starts;
    e0 = n_err;
    i_tx_done = 1'b1;
    idle(1);
    i_tx_done = 1'b0;
    idle(10);
    vectors++; if (n_starts != s0 || n_err != e0)
      begin miscompares++; $display("FAIL rst_tx_quiet: got %0d starts %0d errs want 0 0", n_starts - s0, n_err - e0); end
  endtask

`ifdef UART_ALU_CHECKSUM_EN
  task automatic test_checksum();
    int s0, e0;
    logic [7:0] good[6];
    good = '{8'h12, 8'h34, 8'h00, 8'h01, 8'h20, 8'h07};
    foreach (good[i]) send_byte(good[i]);
    collect_tx(1'b0, 2);
    vectors++; if (txq.size() != 2) begin miscompares++; $display("FAIL chk_good_count: got %0d want 2", txq.size()); end
    else begin
      vectors++; if ({txq[0], txq[1]} !== 16'h1235)
        begin miscompares++; $display("FAIL chk_good_res: got %h%h want 1235", txq[0], txq[1]); end
    end
    s0 = n_starts;
    e0 = n_err;
    for (int i = 0; i < 5; i++) send_byte(good[i]);
    send_byte(8'h08);
    vectors++; if (o_error !== 1'b1 || o_busy !== 1'b0)
      begin miscompares++; $display("FAIL chk_bad_err: got err=%b busy=%b want 1 0", o_error, o_busy); end
    idle(5);
    vectors++; if (n_starts != s0 || n_err - e0 != 1)
      begin miscompares++; $display("FAIL chk_bad_quiet: got %0d starts %0d errs want 0 1", n_starts - s0, n_err - e0); end
  endtask
`endif

  initial begin
    reset      = 1'b1;
    i_data_rx  = 8'h00;
    i_rx_valid = 1'b0;
    i_tx_done  = 1'b0;
    test_reset();
    test_basic();
    test_timeout();
    test_random();
    test_rx_during_tx();
    test_reset_mid_tx();
`ifdef UART_ALU_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
